// File: rtl/ex_mem_pkg.sv
// ----------------------------------------------------------------------------
// ex_mem_pkg
// Shared types and constants for the execute -> memory pipeline register.
//
// Contents:
//   XLEN_DEF / RA_W_DEF  widths the payload struct is built with; the
//                        ex_mem_stage parameters must be left at these values.
//   CR0_LT..CR0_SO       bit positions inside the 4-bit CR0 field {LT,GT,EQ,SO}.
//   ex_mem_payload_t     everything carried from execute to memory.
// ----------------------------------------------------------------------------
package ex_mem_pkg;

  localparam int XLEN_DEF = 64;
  localparam int RA_W_DEF = 5;

  // CR0 bit indices within m_cr0.
  localparam int CR0_LT = 3;
  localparam int CR0_GT = 2;
  localparam int CR0_EQ = 1;
  localparam int CR0_SO = 0;

  typedef struct packed {
    logic [XLEN_DEF-1:0] result;
    logic [RA_W_DEF-1:0] rt;
    logic                reg_we;
    logic                mem_rd;
    logic                mem_wr;
    logic [XLEN_DEF-1:0] st_data;
    logic [3:0]          cr0;
    logic                cr0_we;
  } ex_mem_payload_t;

endpackage

// File: rtl/cr0_gen.sv
// ----------------------------------------------------------------------------
// cr0_gen
// Combinational CR0 and next-summary-overflow generation for one instruction.
//
// Ports:
//   res_msb   in   sign bit of the ALU result
//   alu_zero  in   ALU result is zero
//   alu_ovf   in   ALU signed overflow
//   oe        in   overflow-enable form (instruction updates XER)
//   rc        in   record form (instruction updates CR0)
//   xer_so    in   current architectural XER[SO]
//   so_n      out  XER[SO] as it will be after this instruction
//   cr0       out  {LT,GT,EQ,SO}; all zero when rc=0
// ----------------------------------------------------------------------------
module cr0_gen (
  input  logic       res_msb,
  input  logic       alu_zero,
  input  logic       alu_ovf,
  input  logic       oe,
  input  logic       rc,
  input  logic       xer_so,
  output logic       so_n,
  output logic [3:0] cr0
);
  import ex_mem_pkg::*;

  always_comb begin
    // CR0[SO] must reflect this instruction's own overflow, so it is taken
    // from the post-update summary bit rather than the registered one.
    so_n = oe ? (xer_so | alu_ovf) : xer_so;
    cr0  = 4'b0000;
    if (rc) begin
      cr0[CR0_LT] = res_msb;
      cr0[CR0_GT] = ~res_msb & ~alu_zero;
      cr0[CR0_EQ] = alu_zero;
      cr0[CR0_SO] = so_n;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// ----------------------------------------------------------------------------
// ex_mem_stage
// Pipeline register between the 64-bit ALU (execute) and the memory stage.
// Captures the ALU result and the instruction's destination / memory-control
// fields, derives CR0 for record-form instructions and owns XER[OV]/XER[SO]
// (SO is sticky: it only clears on reset).
//
// Build option (macro EX_MEM_SKID_EN):
//   defined   - two entries (main + skid). ex_ready comes straight from a
//               flop and means "skid slot empty"; an instruction accepted
//               while main is stalled parks in skid and moves to main once
//               main drains, so order is preserved.
//   undefined - single entry; ex_ready = ~m_valid | m_ready (combinational).
//   XER and CR0 behaviour is identical in both builds.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Input accept = ex_valid & ex_ready & ~flush (flush kills only
// the instruction being offered, never held entries); output transfer =
// m_valid & m_ready. While m_valid=1 and m_ready=0 the payload is held
// stable. A simultaneous output transfer and input accept replaces the
// entry with no bubble.
//
// Ports:
//   clk, rst                     clock; asynchronous active-high reset
//   ex_valid / ex_ready / flush  upstream handshake and kill
//   alu_o, alu_ovf, alu_zero     ALU result and flags
//   rc, oe                       record / overflow-enable form bits
//   rt, reg_we, mem_rd, mem_wr,
//   st_data                      instruction fields passed downstream
//   m_valid / m_ready            downstream handshake
//   m_result .. m_st_data        registered payload
//   m_cr0, m_cr0_we              registered CR0 field and its write enable
//   xer_ov, xer_so               architectural XER bits
// ----------------------------------------------------------------------------
module ex_mem_stage #(
  parameter int XLEN = 64,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            flush,
  input  logic [XLEN-1:0] alu_o,
  input  logic            alu_ovf,
  input  logic            alu_zero,
  input  logic            rc,
  input  logic            oe,
  input  logic [RA_W-1:0] rt,
  input  logic            reg_we,
  input  logic            mem_rd,
  input  logic            mem_wr,
  input  logic [XLEN-1:0] st_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [XLEN-1:0] m_result,
  output logic [RA_W-1:0] m_rt,
  output logic            m_reg_we,
  output logic            m_mem_rd,
  output logic            m_mem_wr,
  output logic [XLEN-1:0] m_st_data,
  output logic [3:0]      m_cr0,
  output logic            m_cr0_we,
  output logic            xer_ov,
  output logic            xer_so
);
  import ex_mem_pkg::*;

  ex_mem_payload_t in_p;
  ex_mem_payload_t main_q;
  logic            main_v;
  logic            accept;
  logic            out_xfer;
  logic            so_n;
  logic [3:0]      cr0_w;

  // --------------------------------------------------------------------------
  // CR0 / next-SO generation from the instruction being offered
  // --------------------------------------------------------------------------
  cr0_gen u_cr0_gen (
    .res_msb  (alu_o[XLEN-1]),
    .alu_zero (alu_zero),
    .alu_ovf  (alu_ovf),
    .oe       (oe),
    .rc       (rc),
    .xer_so   (xer_so),
    .so_n     (so_n),
    .cr0      (cr0_w)
  );

  always_comb begin
    in_p         = '0;
    in_p.result  = alu_o;
    in_p.rt      = rt;
    in_p.reg_we  = reg_we;
    in_p.mem_rd  = mem_rd;
    in_p.mem_wr  = mem_wr;
    in_p.st_data = st_data;
    in_p.cr0     = cr0_w;
    in_p.cr0_we  = rc;
  end

  assign accept   = ex_valid & ex_ready & ~flush;
  assign out_xfer = main_v & m_ready;

  // --------------------------------------------------------------------------
  // Architectural XER bits: only accepted oe-form instructions touch them.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xer_ov <= 1'b0;
      xer_so <= 1'b0;
    end else if (accept && oe) begin
      xer_ov <= alu_ovf;
      xer_so <= so_n;
    end
  end

`ifdef EX_MEM_SKID_EN
  // --------------------------------------------------------------------------
  // Two-entry build: main feeds the outputs, skid catches the one instruction
  // that may arrive after main stalls. ready_q always equals ~skid_v; it is
  // kept as its own flop so ex_ready has no path from m_ready.
  // --------------------------------------------------------------------------
  ex_mem_payload_t skid_q;
  logic            skid_v;
  logic            ready_q;

  assign ex_ready = ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q  <= '0;
      skid_q  <= '0;
      main_v  <= 1'b0;
      skid_v  <= 1'b0;
      ready_q <= 1'b1;
    end else if (skid_v) begin
      // Skid full means ex_ready is low, so nothing can be accepted here;
      // the only event is main draining and skid moving up behind it.
      if (out_xfer) begin
        main_q  <= skid_q;
        skid_v  <= 1'b0;
        ready_q <= 1'b1;
      end
    end else if (accept) begin
      if (main_v && !m_ready) begin
        skid_q  <= in_p;
        skid_v  <= 1'b1;
        ready_q <= 1'b0;
      end else begin
        // Main empty or draining this cycle: the new entry goes straight in.
        main_q <= in_p;
        main_v <= 1'b1;
      end
    end else if (out_xfer) begin
      main_v <= 1'b0;
    end
  end
`else
  // --------------------------------------------------------------------------
  // Single-entry build: accept whenever the slot is empty or draining.
  // --------------------------------------------------------------------------
  assign ex_ready = ~main_v | m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      main_v <= 1'b0;
    end else if (accept) begin
      main_q <= in_p;
      main_v <= 1'b1;
    end else if (out_xfer) begin
      main_v <= 1'b0;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Registered outputs
  // --------------------------------------------------------------------------
  assign m_valid   = main_v;
  assign m_result  = main_q.result;
  assign m_rt      = main_q.rt;
  assign m_reg_we  = main_q.reg_we;
  assign m_mem_rd  = main_q.mem_rd;
  assign m_mem_wr  = main_q.mem_wr;
  assign m_st_data = main_q.st_data;
  assign m_cr0     = main_q.cr0;
  assign m_cr0_we  = main_q.cr0_we;

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Pipeline stage register between the 64-bit ALU (execute) and the memory stage of the nPower pipeline. Captures the ALU result, overflow and zero flags together with the instruction's destination and memory-control fields under a valid/ready handshake. Derives the CR0 field for record-form (Rc=1) instructions. Owns the architectural XER[OV]/XER[SO] bits, including sticky summary-overflow accumulation.

## Interface
Parameters:
- XLEN, 64, datapath width; must equal the ALU width.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  execute stage presents an instruction.
- ex_ready  out  1  this stage accepts this cycle.
- flush  in  1  kill the instruction currently offered by execute.
- alu_o  in  XLEN  ALU result.
- alu_ovf  in  1  ALU signed overflow.
- alu_zero  in  1  ALU zero flag.
- rc  in  1  record form; update CR0.
- oe  in  1  overflow-enable form; update XER[OV]/XER[SO].
- rt  in  RA_W  destination register.
- reg_we  in  1  GPR write enable.
- mem_rd  in  1  load.
- mem_wr  in  1  store.
- st_data  in  XLEN  store data.
- m_valid  out  1  payload valid toward the memory stage.
- m_ready  in  1  memory stage accepts.
- m_result, m_rt, m_reg_we, m_mem_rd, m_mem_wr, m_st_data  out  (widths as inputs)  registered payload.
- m_cr0  out  4  {LT,GT,EQ,SO}.
- m_cr0_we  out  1  registered rc.
- xer_ov  out  1  architectural XER[OV].
- xer_so  out  1  architectural XER[SO] (sticky).

## Operation
- Accept = ex_valid & ex_ready & ~flush. Only accepted instructions enter this stage or change XER.
- Flush kills only the incoming transfer. Entries already held are older and are retained.
- On accept with oe=1:
  - xer_ov <= alu_ovf.
  - xer_so <= xer_so | alu_ovf.
- On accept with oe=0: XER is unchanged.
- CR0 is computed from the post-update SO, i.e. so_n = oe ? (xer_so | alu_ovf) : xer_so.
  - LT = alu_o[XLEN-1].
  - GT = ~alu_o[XLEN-1] & ~alu_zero.
  - EQ = alu_zero.
  - SO = so_n.
- When rc=0: m_cr0 = 0 and m_cr0_we = 0.
- Output transfer = m_valid & m_ready.
- Payload is stable while m_valid=1 and m_ready=0.
- Simultaneous output transfer and input accept: the new entry replaces the old one; no bubble.

## Timing
- Reset values: m_valid=0, all m_* payload and m_cr0 = 0, xer_ov=0, xer_so=0, ex_ready=1.
- Latency: 1 cycle from accept to m_valid.
- XER changes are visible in the cycle after accept.
- Throughput: 1 instruction/cycle while m_ready=1.
- Reset mid-operation clears all entries and the XER bits immediately (asynchronous). The first accept is possible in the cycle after rst deasserts.
- Back-to-back oe instructions chain SO correctly: the second instruction uses the first's updated SO.

## Configuration
- EX_MEM_SKID_EN defined:
  - Two-entry skid buffer (main + skid); ex_ready is a flop output, so there is no combinational path from m_ready.
  - ex_ready = skid slot empty.
  - An entry accepted while main is stalled goes to skid.
  - Order is preserved: main drains first, then skid moves to main.
- EX_MEM_SKID_EN undefined:
  - Single entry; ex_ready = ~m_valid | m_ready (combinational).
- XER/CR0 semantics are identical in both builds.

## Structure
- Package ex_mem_pkg contains:
  - Payload struct: result, rt, reg_we, mem_rd, mem_wr, st_data, cr0, cr0_we.
  - CR0 bit-index constants: LT=3, GT=2, EQ=1, SO=0.
- Sub-module cr0_gen: combinational CR0 and so_n generation, instantiated once.

## Test plan
- Reset, then accept add result 0x0000_0000_0000_0005 with rc=1 → next cycle m_valid=1, m_result=5, m_cr0=4'b0100.
- Result 0xFFFF_FFFF_FFFF_FFFE, rc=1, oe=1, alu_ovf=0 → m_cr0=4'b1000, xer_ov=0, xer_so=0.
- oe=1 with alu_ovf=1, then oe=1 with alu_ovf=0 and zero result (rc=1) → xer_ov ends at 0, xer_so stays 1, second m_cr0=4'b0011.
- Hold m_ready=0 for 3 cycles while ex_valid=1 with results 1, 2, 3:
  - Single-entry build: ex_ready drops after the first accept.
  - Skid build: ex_ready drops after the second accept.
  - On release, outputs appear in order 1, 2, 3 with no loss or duplication.
- flush=1 with ex_valid=1, oe=1, alu_ovf=1 → nothing accepted, xer_so unchanged, and any held entry remains valid.
- Assert rst while two entries are held → m_valid=0 and xer_so=0 in the same cycle, without waiting for a clock edge.
